// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// State codes are plain localparams so that older blocks comparing raw
// two-bit state values keep working unchanged.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;
    localparam arb_state_t DONE  = 2'd3;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Owner selection for the memory arbiter.
// Data normally wins; once STARVE_MAX data grants have gone by while a
// fetch was waiting, the fetch is forced through. The streak counter only
// moves during arbitration cycles (arb_en high).
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       i_req,
    input  logic       i_block,
    input  logic       d_req,
    output logic       grant,
    output arb_owner_t owner
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] streak;
    logic          i_eligible;
    logic          starved;

    assign i_eligible = i_req & ~i_block;
    assign starved    = (streak == SW'(STARVE_MAX));

    // Grant whenever anything eligible is pending; pick data unless the fetch is starved
    always_comb begin
        grant = arb_en & (i_eligible | d_req);
        owner = OWN_I;
        if (d_req && !(i_eligible && starved)) begin
            owner = OWN_D;
        end
    end

    // Saturating count of data grants taken while a fetch was waiting
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak <= '0;
        end else if (arb_en) begin
            if (grant && owner == OWN_I) begin
                streak <= '0;
            end else if (!i_req) begin
                streak <= '0;
            end else if (grant && owner == OWN_D && !starved) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction
// fetch and data load/store. One transaction in flight at a time:
// IDLE (arbitrate) -> ISSUE (mem_req until mem_ready) -> WAIT (until
// mem_rvalid) -> DONE (one-cycle done pulse to the owner).
// Optional feature: define MEM_ARB_FLUSH_EN to add the i_flush input,
// which cancels an in-flight fetch and blocks new fetch grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
`ifdef MEM_ARB_FLUSH_EN
    input  logic        i_flush,
`endif
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    arb_state_t state;
    arb_owner_t owner_q;
    arb_owner_t pick_owner;
    logic       grant;
    logic       fetch_block;
    logic       cancel_now;

`ifdef MEM_ARB_FLUSH_EN
    logic cancel_q;
    logic flush_hit;

    assign flush_hit   = i_flush && (owner_q == OWN_I) &&
                         (state == ISSUE || state == WAIT);
    assign fetch_block = i_flush;
    assign cancel_now  = cancel_q | flush_hit;

    // Remember that the in-flight fetch was flushed so its result is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            cancel_q <= 1'b0;
        end else if (state == IDLE) begin
            cancel_q <= 1'b0;
        end else if (flush_hit) begin
            cancel_q <= 1'b1;
        end
    end
`else
    assign fetch_block = 1'b0;
    assign cancel_now  = 1'b0;
`endif

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (state == IDLE),
        .i_req   (i_req),
        .i_block (fetch_block),
        .d_req   (d_req),
        .grant   (grant),
        .owner   (pick_owner)
    );

    // Transaction sequencer: latch the winner, hand-shake with memory, return data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner_q   <= OWN_I;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q <= pick_owner;
                        mem_req <= 1'b1;
                        state   <= ISSUE;
                        if (pick_owner == OWN_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_size  <= d_size;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_size  <= SZ_W;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= DONE;
                        if (owner_q == OWN_D) begin
                            d_done <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else if (!cancel_now) begin
                            i_done  <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter.
// A transaction-level model tracks pending requests, the data-over-fetch
// priority with its starvation limit, and the rdata each requester should
// hold; a bench-side memory responder applies random ready/rvalid delays.
// Define MEM_ARB_FLUSH_EN to also exercise the fetch-flush feature.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

`ifdef MEM_ARB_FLUSH_EN
    localparam bit FLUSH_BUILT = 1'b1;
`else
    localparam bit FLUSH_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
`ifdef MEM_ARB_FLUSH_EN
    logic        i_flush;
`endif
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          pend_i;
    bit          pend_d;
    logic [31:0] ia;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [1:0]  dsz;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    int          run;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
`ifdef MEM_ARB_FLUSH_EN
        .i_flush    (i_flush),
`endif
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_size     (d_size),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic driveReqs();
        i_req   = pend_i;
        i_addr  = ia;
        d_req   = pend_d;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_size  = dsz;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_req"},   mem_req,   0);
        checkOutput({tag, "_mem_we"},    mem_we,    0);
        checkOutput({tag, "_mem_addr"},  mem_addr,  0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_mem_size"},  mem_size,  0);
        checkOutput({tag, "_i_done"},    i_done,    0);
        checkOutput({tag, "_d_done"},    d_done,    0);
        checkOutput({tag, "_i_rdata"},   i_rdata,   0);
        checkOutput({tag, "_d_rdata"},   d_rdata,   0);
    endtask

    task automatic newFetch();
        pend_i = 1'b1;
        ia     = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic newData();
        pend_d = 1'b1;
        dwe    = 1'($urandom_range(0, 1));
        da     = $urandom;
        dwd    = $urandom;
        dsz    = 2'($urandom_range(0, 2));
    endtask

    // Called at the falling edge of an IDLE cycle with at least one request
    // pending; runs one whole transaction and returns at the next IDLE cycle.
    task automatic applyStimulus(input int rd, input int vd, input logic [31:0] rdata,
                                 input bit flush, input bit spurious);
        bit          own_d;
        bit          cancelled;
        logic [31:0] xa;
        logic [31:0] xwd;
        logic        xwe;
        logic [1:0]  xsz;

        driveReqs();
        if (spurious) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        checkOutput("idle_mem_req", mem_req, 0);

        own_d = pend_d && !(pend_i && run == STARVE_MAX);
        if (own_d && pend_i) run = (run < STARVE_MAX) ? run + 1 : run;
        else                 run = 0;

        if (own_d) begin
            xa = da; xwe = dwe; xsz = dsz; xwd = dwd;
        end else begin
            xa = ia; xwe = 1'b0; xsz = 2'b10; xwd = '0;
        end

        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k <= rd; k++) begin
            checkOutput("issue_mem_req",  mem_req,  1);
            checkOutput("issue_mem_addr", mem_addr, xa);
            checkOutput("issue_mem_we",   mem_we,   xwe);
            checkOutput("issue_mem_size", mem_size, xsz);
            if (xwe) checkOutput("issue_mem_wdata", mem_wdata, xwd);
            mem_ready = (k == rd);
            @(negedge clk);
        end
        mem_ready = 1'b0;

        cancelled = 1'b0;
        for (int k = 0; k <= vd; k++) begin
            checkOutput("wait_i_done",   i_done,   0);
            checkOutput("wait_d_done",   d_done,   0);
            checkOutput("wait_mem_addr", mem_addr, xa);
            if (FLUSH_BUILT && flush && k == 0 && !own_d) cancelled = 1'b1;
`ifdef MEM_ARB_FLUSH_EN
            i_flush = flush && (k == 0);
`endif
            mem_rvalid = (k == vd);
            mem_rdata  = (k == vd) ? rdata : $urandom;
            @(negedge clk);
        end
`ifdef MEM_ARB_FLUSH_EN
        i_flush = 1'b0;
`endif
        mem_rvalid = 1'b0;

        if (own_d) begin
            if (!xwe) exp_d_rdata = rdata;
            pend_d = 1'b0;
        end else begin
            if (!cancelled) exp_i_rdata = rdata;
            pend_i = 1'b0;
        end
        checkOutput("done_i_done",  i_done,  (!own_d && !cancelled) ? 1 : 0);
        checkOutput("done_d_done",  d_done,  own_d ? 1 : 0);
        checkOutput("done_i_rdata", i_rdata, exp_i_rdata);
        checkOutput("done_d_rdata", d_rdata, exp_d_rdata);
        driveReqs();

        @(negedge clk);
        checkOutput("after_i_done", i_done, 0);
        checkOutput("after_d_done", d_done, 0);
    endtask

    task automatic idleCycle();
        driveReqs();
        run = 0;
        if ($urandom_range(0, 1) == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("idle_hold_req",  mem_req, 0);
        checkOutput("idle_hold_done", i_done | d_done, 0);
    endtask

    initial begin
        rst = 1'b0;
        pend_i = 0; pend_d = 0;
        ia = 0; dwe = 0; da = 0; dwd = 0; dsz = 0;
        exp_i_rdata = 0; exp_d_rdata = 0; run = 0;
        driveReqs();
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
`ifdef MEM_ARB_FLUSH_EN
        i_flush = 0;
`endif
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Lone fetch, fastest memory
        pend_i = 1; ia = 32'h0000_0100;
        applyStimulus(0, 0, 32'h0050_0093, 0, 0);

        // Simultaneous store and fetch: store first, then fetch
        pend_i = 1; ia = 32'h0000_0104;
        pend_d = 1; dwe = 1; da = 32'h0000_2000; dwd = 32'hDEAD_BEEF; dsz = 2'b10;
        applyStimulus(0, 0, 32'h1111_1111, 0, 0);
        applyStimulus(0, 0, 32'h0000_0013, 0, 0);

        // Data held continuously with fetch waiting: D,D,D,D,I repeating
        pend_i = 1; ia = 32'h0000_0200;
        for (int t = 0; t < 10; t++) begin
            if (!pend_d) newData();
            if (!pend_i) begin pend_i = 1; ia = 32'h0000_0200 + 32'(t * 4); end
            applyStimulus(0, 0, $urandom, 0, 0);
        end
        while (pend_i || pend_d) applyStimulus(0, 0, $urandom, 0, 0);

        // Slow memory with a spurious response while idle
        pend_d = 1; dwe = 0; da = 32'h0000_3000; dsz = 2'b01; dwd = 0;
        applyStimulus(3, 5, 32'hCAFE_F00D, 0, 1);

        // Reset while waiting for the memory response
        pend_i = 1; ia = 32'h0000_0300;
        driveReqs();
        @(negedge clk);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        rst = 0;
        @(negedge clk);
        pend_i = 0;
        driveReqs();
        rst = 1;
        exp_i_rdata = 0; exp_d_rdata = 0; run = 0;
        checkResetOutputs("midrst");
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("midrst_no_i_done", i_done, 0);
            checkOutput("midrst_no_d_done", d_done, 0);
            checkOutput("midrst_no_req",    mem_req, 0);
            @(negedge clk);
        end

`ifdef MEM_ARB_FLUSH_EN
        // Flushed fetch is dropped; the next fetch completes normally
        pend_i = 1; ia = 32'h0000_0400;
        applyStimulus(1, 2, 32'h1234_5678, 1, 0);
        pend_i = 1; ia = 32'h0000_0404;
        applyStimulus(0, 0, 32'h8765_4321, 0, 0);
`endif

        // Random mix of requests and memory timing
        for (int t = 0; t < 200; t++) begin
            if (!pend_i && $urandom_range(0, 99) < 60) newFetch();
            if (!pend_d && $urandom_range(0, 99) < 75) newData();
            if (!pend_i && !pend_d) begin
                idleCycle();
            end else begin
                applyStimulus($urandom_range(0, 3), $urandom_range(0, 4), $urandom,
                              FLUSH_BUILT && ($urandom_range(0, 9) == 0),
                              $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares one single-port, variable-latency unified memory between the instruction-fetch requester and the data (load/store) requester of the five-stage RV32I pipeline. It arbitrates, issues one transaction at a time, waits for the memory response and returns data plus a one-cycle completion pulse to the winning requester. The pipeline uses the absence of `i_done`/`d_done` to stall IF and MEM respectively.

## Interface
Parameters:
- `STARVE_MAX`, 4, consecutive data grants allowed while `i_req` waits before instruction is forced.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous active-low reset
- `i_req` in 1, instruction fetch request (level)
- `i_addr` in 32, fetch address
- `i_rdata` out 32, fetched word
- `i_done` out 1, fetch complete pulse
- `d_req` in 1, data request (level)
- `d_we` in 1, 1 = store
- `d_addr` in 32, data address
- `d_wdata` in 32, store data
- `d_size` in 2, 00 byte, 01 half, 10 word
- `d_rdata` out 32, load data (raw; sign/zero extension stays in the MEM stage)
- `d_done` out 1, data complete pulse
- `mem_req` out 1, memory request
- `mem_we`, `mem_addr` (32), `mem_wdata` (32), `mem_size` (2) out, registered copy of granted request
- `mem_ready` in 1, memory accepts request this cycle
- `mem_rvalid` in 1, response valid (loads, fetches and stores all return one)
- `mem_rdata` in 32, response data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request, pick owner, latch address/data/size/we into `mem_*` registers, go ISSUE. Otherwise stay.
- Pick rule: data beats instruction, except when `streak == STARVE_MAX` and `i_req` is high, in which case instruction wins.
- `streak`: saturating counter; +1 on each data grant while `i_req` high; cleared on instruction grant or when `i_req` low in IDLE.
- ISSUE: `mem_req`=1; on `mem_ready` go WAIT. Fetch grant always drives `mem_we`=0, `mem_size`=10.
- WAIT: on `mem_rvalid` capture `mem_rdata` into owner's rdata register (stores leave `d_rdata` unchanged), go DONE.
- DONE: owner's done =1 for exactly this cycle; go IDLE. No arbitration in DONE.
- Requests are levels: `req` still high in the IDLE cycle after DONE is a new transaction; requesters keep addr/data stable from raise to done.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`/`mem_wdata`=0, `mem_size`=0, `i_done`=`d_done`=0, `i_rdata`=`d_rdata`=0, `streak`=0. Reset mid-transaction abandons it; no done is generated.
- Min latency: req sampled cycle N → `mem_req` N+1 → (`mem_ready` N+1) → `mem_rvalid` earliest N+2 → done N+3. Next grant decided N+4. Peak throughput one transaction per 4 cycles.
- `mem_ready` low holds ISSUE with all `mem_*` outputs stable.
- `i_rdata`/`d_rdata` valid from done cycle, held until owner's next completion.
- Both requests in same IDLE cycle: rule above; loser waits, no request lost.

## Configuration
- `MEM_ARB_FLUSH_EN` defined: extra input `i_flush` (1). While flush is high in ISSUE/WAIT with instruction owner, transaction is marked cancelled: it still completes on the memory side, but DONE suppresses `i_done` and leaves `i_rdata` unchanged. `i_flush` in IDLE with `i_req` high blocks the fetch grant that cycle. Data transactions never cancelled.
- Undefined: no `i_flush` port; every granted fetch produces `i_done`.

## Structure
- `mem_arb_pkg`: `arb_state_t` (IDLE/ISSUE/WAIT/DONE), `arb_owner_t` (OWN_I/OWN_D), size constants `SZ_B`/`SZ_H`/`SZ_W`.
- Sub-module `mem_arb_pick`: combinational owner selection plus `streak` counter register; FSM and capture registers stay in `mem_arbiter`.

## Test plan
- Lone fetch, `i_addr`=0x100, `mem_ready` same cycle, `mem_rvalid` next with 0x00500093 → `i_done` 3 cycles after req, `i_rdata`=0x00500093, `d_done` never.
- `i_req`/`d_req` together, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF → store issued first (`mem_we`=1, `mem_size`=10), `d_done`; fetch issued next.
- `d_req` held high 6 transactions with `i_req` high, STARVE_MAX=4 → grants D,D,D,D,I,D…; `streak` resets after I.
- `mem_ready` low 3 cycles then `mem_rvalid` delayed 5 → `mem_*` stable throughout, single done pulse; spurious `mem_rvalid` in IDLE ignored.
- `rst`=0 during WAIT → next cycle all outputs at reset values; later `mem_rvalid` produces no done.
- With `MEM_ARB_FLUSH_EN`: `i_flush` pulse in WAIT of fetch → no `i_done`, `i_rdata` unchanged, following fetch completes normally.
